// File: rtl/board_io_pkg.sv
// Shared defaults and width helpers for the board I/O front end.
package board_io_pkg;

  localparam int DEBOUNCE_10MS_100MHZ = 1000000;
  localparam int DEFAULT_PWM_BITS     = 8;
  localparam int DEFAULT_SYNC_STAGES  = 2;

  // Counter width able to hold 0 .. n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One-bit input conditioner: synchroniser chain, counting debouncer and
// registered rise/fall strobes that coincide with the level change.
module io_debounce
  import board_io_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   level_reg;
  logic                   rise_reg;
  logic                   fall_reg;
  logic                   synced;

  assign synced = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      // Any return to the accepted level restarts the stability window.
      if (synced == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= ~level_reg;
        cnt_reg   <= '0;
        rise_reg  <= ~level_reg;
        fall_reg  <= level_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O front end: debounced buttons/switches with strobes, and
// per-colour PWM LED drive with period-aligned duty shadowing.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int N_SW            = 4,
  parameter int N_RGB           = 2,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
  parameter int PWM_BITS        = DEFAULT_PWM_BITS
) (
  input  logic                      CLK100MHZ,
  input  logic                      RESETN,
  input  logic [N_BTN-1:0]          BTN,
  input  logic [N_SW-1:0]           SW,
  output logic [N_BTN-1:0]          btn_level,
  output logic [N_BTN-1:0]          btn_press,
  output logic [N_BTN-1:0]          btn_release,
  output logic [N_SW-1:0]           sw_level,
  input  logic [N_RGB*PWM_BITS-1:0] r_duty,
  input  logic [N_RGB*PWM_BITS-1:0] g_duty,
  input  logic [N_RGB*PWM_BITS-1:0] b_duty,
  output logic [N_RGB-1:0]          RLED,
  output logic [N_RGB-1:0]          GLED,
  output logic [N_RGB-1:0]          BLED
);

  // Counter runs 0 .. 2^PWM_BITS-2 so a full-scale duty stays solidly on.
  localparam logic [PWM_BITS-1:0] PCNT_LAST = ~PWM_BITS'(1);

  logic [N_SW-1:0]     sw_rise_unused;
  logic [N_SW-1:0]     sw_fall_unused;
  logic [PWM_BITS-1:0] pcnt_reg;
  logic                period_end;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      io_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk  (CLK100MHZ),
        .rst_n(RESETN),
        .din  (BTN[gi]),
        .level(btn_level[gi]),
        .rise (btn_press[gi]),
        .fall (btn_release[gi])
      );
    end

    for (gi = 0; gi < N_SW; gi++) begin : g_sw
      io_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk  (CLK100MHZ),
        .rst_n(RESETN),
        .din  (SW[gi]),
        .level(sw_level[gi]),
        .rise (sw_rise_unused[gi]),
        .fall (sw_fall_unused[gi])
      );
    end
  endgenerate

  assign period_end = (pcnt_reg == PCNT_LAST);

  always_ff @(posedge CLK100MHZ or negedge RESETN) begin
    if (!RESETN) begin
      pcnt_reg <= '0;
    end else begin
      pcnt_reg <= period_end ? '0 : pcnt_reg + 1'b1;
    end
  end

  generate
    for (gi = 0; gi < N_RGB; gi++) begin : g_rgb
      logic [PWM_BITS-1:0] r_shadow_reg, g_shadow_reg, b_shadow_reg;
      logic                r_led_reg, g_led_reg, b_led_reg;

      always_ff @(posedge CLK100MHZ or negedge RESETN) begin
        if (!RESETN) begin
          r_shadow_reg <= '0;
          g_shadow_reg <= '0;
          b_shadow_reg <= '0;
          r_led_reg    <= 1'b0;
          g_led_reg    <= 1'b0;
          b_led_reg    <= 1'b0;
        end else begin
          if (period_end) begin
            r_shadow_reg <= r_duty[gi*PWM_BITS +: PWM_BITS];
            g_shadow_reg <= g_duty[gi*PWM_BITS +: PWM_BITS];
            b_shadow_reg <= b_duty[gi*PWM_BITS +: PWM_BITS];
          end
          r_led_reg <= (pcnt_reg < r_shadow_reg);
          g_led_reg <= (pcnt_reg < g_shadow_reg);
          b_led_reg <= (pcnt_reg < b_shadow_reg);
        end
      end

      assign RLED[gi] = r_led_reg;
      assign GLED[gi] = g_led_reg;
      assign BLED[gi] = b_led_reg;
    end
  endgenerate

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with short debounce and 4-bit PWM.
module tb_board_io_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] btn, sw;
  logic [3:0] btn_level, btn_press, btn_release, sw_level;
  logic [7:0] r_duty, g_duty, b_duty;
  logic [1:0] rled, gled, bled;

  int n_cmp = 0;
  int n_bad = 0;

  board_io_ctrl #(
    .N_BTN(4), .N_SW(4), .N_RGB(2),
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .PWM_BITS(4)
  ) dut (
    .CLK100MHZ(clk), .RESETN(rstn), .BTN(btn), .SW(sw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .sw_level(sw_level), .r_duty(r_duty), .g_duty(g_duty), .b_duty(b_duty),
    .RLED(rled), .GLED(gled), .BLED(bled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until RLED[0] (duty 5) rises; afterwards pcnt == 1.
  task automatic sync_period(output bit found);
    logic prev;
    found = 0;
    prev  = rled[0];
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (!prev && rled[0]) found = 1;
      prev = rled[0];
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_lvl"}, 32'(btn_level), 32'h0);
    chk({tag, "_prs"}, 32'(btn_press), 32'h0);
    chk({tag, "_rel"}, 32'(btn_release), 32'h0);
    chk({tag, "_sw"},  32'(sw_level), 32'h0);
    chk({tag, "_led"}, 32'({rled, gled, bled}), 32'h0);
  endtask

  // Release reset with BTN held high, expect level after exactly 10 cycles.
  task automatic recover(input string tag);
    int r_hi;
    r_hi = 0;
    rstn = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      r_hi += int'(rled[0]) + int'(rled[1]);
      if (i == 9)  chk({tag, "_lvl9"}, 32'(btn_level), 32'h0);
      if (i == 10) begin
        chk({tag, "_lvl10"}, 32'(btn_level), 32'hF);
        chk({tag, "_prs10"}, 32'(btn_press), 32'hF);
      end
      if (i == 11) chk({tag, "_prs11"}, 32'(btn_press), 32'h0);
    end
    chk({tag, "_led_first_period"}, 32'(r_hi), 32'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad, cnt[6], g_hi;
    bit found;

    // Reset with everything active.
    rstn = 1'b0; btn = 4'hF; sw = 4'h0;
    r_duty = 8'hFF; g_duty = 8'hFF; b_duty = 8'hFF;
    tick(3);
    all_zero("reset");
    recover("rst1");

    // Bring BTN[0] low, then bounce it before settling high.
    btn = 4'hE;
    tick(10);
    chk("b0_low_rel", 32'(btn_release), 32'h1);
    tick(2);
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      btn[0] = ~btn[0];
      repeat (3) begin
        tick();
        if (btn_press != 4'h0 || btn_level[0]) bad++;
      end
    end
    btn[0] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (btn_press != 4'h0 || btn_level[0]) bad++;
    end
    chk("bounce_quiet", 32'(bad), 32'd0);
    tick();
    chk("bounce_lvl", 32'(btn_level), 32'hF);
    chk("bounce_prs", 32'(btn_press), 32'h1);

    // BTN[2] release together with a switch change.
    tick(3);
    btn = 4'hB; sw = 4'h5;
    tick(9);
    chk("rel_pre_rel", 32'(btn_release), 32'h0);
    chk("rel_pre_sw", 32'(sw_level), 32'h0);
    tick();
    chk("rel_lvl", 32'(btn_level), 32'hB);
    chk("rel_rel", 32'(btn_release), 32'h4);
    chk("rel_prs", 32'(btn_press), 32'h0);
    chk("rel_sw", 32'(sw_level), 32'h5);
    tick();
    chk("rel_rel_post", 32'(btn_release), 32'h0);

    // PWM duty counts over one full period.
    r_duty = {4'd10, 4'd5}; g_duty = {4'd0, 4'd3}; b_duty = {4'd0, 4'd15};
    tick(32);
    for (int k = 0; k < 6; k++) cnt[k] = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      cnt[0] += int'(rled[0]); cnt[1] += int'(rled[1]);
      cnt[2] += int'(gled[0]); cnt[3] += int'(gled[1]);
      cnt[4] += int'(bled[0]); cnt[5] += int'(bled[1]);
    end
    chk("pwm_r0_d5", 32'(cnt[0]), 32'd5);
    chk("pwm_r1_d10", 32'(cnt[1]), 32'd10);
    chk("pwm_g0_d3", 32'(cnt[2]), 32'd3);
    chk("pwm_g1_d0", 32'(cnt[3]), 32'd0);
    chk("pwm_b0_d15", 32'(cnt[4]), 32'd15);
    chk("pwm_b1_d0", 32'(cnt[5]), 32'd0);

    // Mid-period duty change on GLED[0]: 3 -> 12 at pcnt 6.
    sync_period(found);
    chk("mid_sync", 32'(found), 32'd1);
    g_hi = int'(gled[0]);
    for (int i = 1; i < 15; i++) begin
      tick();
      if (i == 5) g_duty = {4'd0, 4'd12};
      g_hi += int'(gled[0]);
    end
    chk("mid_cur_period", 32'(g_hi), 32'd3);
    g_hi = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      g_hi += int'(gled[0]);
    end
    chk("mid_next_period", 32'(g_hi), 32'd12);

    // Reset at debounce cnt 5 and pcnt 9.
    sync_period(found);
    chk("rst2_sync", 32'(found), 32'd1);
    tick();
    btn = 4'hF;
    tick(7);
    chk("rst2_pre_led", 32'({rled[1], bled[0]}), 32'h3);
    rstn = 1'b0;
    #1;
    all_zero("rst2");
    tick(2);
    recover("rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
